// File: rtl/meter_countdown.sv
// Parking-meter time base. Holds the remaining seconds, applies preset/add
// requests and 1 Hz countdown ticks, converts the count to four BCD digits
// with a sequential double-dabble, and drives a blinking display enable.
module meter_countdown #(
    parameter int MAX_TIME = 9999,
    parameter int LOW_TIME = 200,
    parameter int ADD_A    = 60,
    parameter int ADD_B    = 120,
    parameter int ADD_C    = 180,
    parameter int ADD_D    = 300,
    parameter int PRE_A    = 15,
    parameter int PRE_B    = 185
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_1Hz,
    input  logic        clk_blink,
    input  logic        add_a,
    input  logic        add_b,
    input  logic        add_c,
    input  logic        add_d,
    input  logic        pre_a,
    input  logic        pre_b,
    output logic [13:0] secs,
    output logic [15:0] bcd,
    output logic        bcd_valid,
    output logic        disp_on
);

    typedef enum logic [1:0] {ZERO, LOW, HIGH} meter_state_t;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    localparam logic [14:0] MAX15 = 15'(MAX_TIME);

    // ---------------- time base ----------------
    logic         r_1hz_prev;
    logic [13:0]  r_secs;
    logic         r_disp;
    logic         w_tick;
    logic         w_add_any;
    logic [14:0]  w_add_amt;
    logic [14:0]  w_sum;
    logic [13:0]  w_secs_next;
    meter_state_t w_mstate;

    // A tick is the first cycle in which clk_1Hz is seen high.
    assign w_tick = clk_1Hz & ~r_1hz_prev;
    assign w_sum  = {1'b0, r_secs} + w_add_amt;

    // Add request select: lowest letter wins when several are raised together.
    always_comb begin
        w_add_any = 1'b1;
        w_add_amt = '0;
        if (add_a)      w_add_amt = 15'(ADD_A);
        else if (add_b) w_add_amt = 15'(ADD_B);
        else if (add_c) w_add_amt = 15'(ADD_C);
        else if (add_d) w_add_amt = 15'(ADD_D);
        else            w_add_any = 1'b0;
    end

    // Next remaining-seconds value: preset beats add, add beats a bare tick.
    always_comb begin
        w_secs_next = r_secs;
        if (pre_a) begin
            w_secs_next = 14'(PRE_A);
        end else if (pre_b) begin
            w_secs_next = 14'(PRE_B);
        end else if (w_add_any) begin
            if (w_sum >= MAX15)
                w_secs_next = 14'(MAX_TIME);
            else if (w_tick)
                w_secs_next = 14'(w_sum - 15'd1);
            else
                w_secs_next = w_sum[13:0];
        end else if (w_tick && (r_secs != 14'd0)) begin
            w_secs_next = r_secs - 14'd1;
        end
    end

    // Meter state decoded from the registered count.
    always_comb begin
        w_mstate = ZERO;
        if (r_secs >= 14'(LOW_TIME))
            w_mstate = HIGH;
        else if (r_secs != 14'd0)
            w_mstate = LOW;
    end

    // Count register, edge-detect history and display enable.
    always_ff @(posedge clk) begin
        r_1hz_prev <= clk_1Hz;
        if (rst) begin
            r_secs <= '0;
            r_disp <= 1'b0;
        end else begin
            r_secs <= w_secs_next;
            case (w_mstate)
                HIGH:    r_disp <= 1'b1;
                LOW:     r_disp <= clk_1Hz;
                default: r_disp <= clk_blink;
            endcase
        end
    end

    // ---------------- BCD converter ----------------
    conv_state_t r_cstate, w_cstate_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic [29:0] r_shift, w_shift_next;
    logic [29:0] w_shift_adj;
    logic [15:0] r_bcd, w_bcd_next;
    logic        r_valid, w_valid_next;
    logic [13:0] r_secs_last, w_secs_last_next;
    logic        w_changed;

    // The last value handed to the converter lags r_secs by one cycle after any change.
    assign w_changed = (r_secs != r_secs_last);

    // Add-3 correction on every BCD digit that is 5 or more, before each shift.
    assign w_shift_adj[13:0] = r_shift[13:0];
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dabble
            logic [3:0] w_digit;
            assign w_digit = r_shift[14 + 4*gi +: 4];
            assign w_shift_adj[14 + 4*gi +: 4] = (w_digit >= 4'd5) ? (w_digit + 4'd3) : w_digit;
        end
    endgenerate

    // Converter next-state: a fresh count always restarts; the result is published only at DONE.
    always_comb begin
        w_cstate_next    = r_cstate;
        w_cnt_next       = r_cnt;
        w_shift_next     = r_shift;
        w_bcd_next       = r_bcd;
        w_valid_next     = r_valid;
        w_secs_last_next = r_secs_last;
        if (w_changed) begin
            w_cstate_next    = SHIFT;
            w_cnt_next       = 4'd0;
            w_shift_next     = {16'h0000, r_secs};
            w_valid_next     = 1'b0;
            w_secs_last_next = r_secs;
        end else begin
            case (r_cstate)
                SHIFT: begin
                    w_shift_next = {w_shift_adj[28:0], 1'b0};
                    w_cnt_next   = r_cnt + 4'd1;
                    if (r_cnt == 4'd13)
                        w_cstate_next = DONE;
                end
                DONE: begin
                    w_bcd_next    = r_shift[29:14];
                    w_valid_next  = 1'b1;
                    w_cstate_next = IDLE;
                end
                default: w_cstate_next = IDLE;
            endcase
        end
    end

    // Converter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cstate    <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_bcd       <= '0;
            r_valid     <= 1'b1;
            r_secs_last <= '0;
        end else begin
            r_cstate    <= w_cstate_next;
            r_cnt       <= w_cnt_next;
            r_shift     <= w_shift_next;
            r_bcd       <= w_bcd_next;
            r_valid     <= w_valid_next;
            r_secs_last <= w_secs_last_next;
        end
    end

    assign secs      = r_secs;
    assign bcd       = r_bcd;
    assign bcd_valid = r_valid;
    assign disp_on   = r_disp;

endmodule

// File: tb/tb_meter_countdown.sv
// Testbench for meter_countdown: directed scenarios followed by random
// stimulus, checked against a behavioural model and a BCD scoreboard.
module tb_meter_countdown;

    logic        clk = 1'b0;
    logic        rst, clk_1Hz, clk_blink;
    logic        add_a, add_b, add_c, add_d, pre_a, pre_b;
    logic [13:0] secs;
    logic [15:0] bcd;
    logic        bcd_valid, disp_on;

    always #5 clk = ~clk;

    meter_countdown dut (
        .clk(clk), .rst(rst), .clk_1Hz(clk_1Hz), .clk_blink(clk_blink),
        .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_d(add_d),
        .pre_a(pre_a), .pre_b(pre_b),
        .secs(secs), .bcd(bcd), .bcd_valid(bcd_valid), .disp_on(disp_on)
    );

    typedef struct { int e; int v; } ent_t;
    ent_t q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int m_secs  = 0;
    int m_disp  = 0;
    bit m_prev1 = 1'b0;
    int model_edge = 0;
    int rst_edge   = -100;

    function automatic int to_bcd(int v);
        return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
               (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, model_edge);
        end
    endtask

    // Reference model: one call per clock edge, using the levels just applied.
    task automatic model_update(bit r, bit [3:0] adds, bit [1:0] pres);
        int  old;
        int  amt;
        bit  tick;
        old = m_secs;
        model_edge++;
        if (r) begin
            m_secs   = 0;
            m_disp   = 0;
            m_prev1  = clk_1Hz;
            rst_edge = model_edge;
            q.delete();
            return;
        end
        tick    = clk_1Hz && !m_prev1;
        m_prev1 = clk_1Hz;
        m_disp  = (old >= 200) ? 1 : (old > 0) ? int'(clk_1Hz) : int'(clk_blink);
        if (pres[0])      m_secs = 15;
        else if (pres[1]) m_secs = 185;
        else if (adds != 4'b0) begin
            amt = adds[0] ? 60 : adds[1] ? 120 : adds[2] ? 180 : 300;
            if (old + amt >= 9999) m_secs = 9999;
            else                   m_secs = old + amt - int'(tick);
        end else if (tick && old > 0) begin
            m_secs = old - 1;
        end
        if (m_secs != old) q.push_back('{model_edge, m_secs});
    endtask

    task automatic drive_cycle(bit r, bit [3:0] adds, bit [1:0] pres);
        rst   = r;
        add_a = adds[0]; add_b = adds[1]; add_c = adds[2]; add_d = adds[3];
        pre_a = pres[0]; pre_b = pres[1];
        @(posedge clk);
        model_update(r, adds, pres);
        #1;
        check("secs", int'(secs), m_secs);
        check("disp_on", int'(disp_on), m_disp);
        if (r) begin
            check("rst_bcd", int'(bcd), 0);
            check("rst_bcd_valid", int'(bcd_valid), 1);
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            clk_blink = ~clk_blink;
            drive_cycle(1'b0, 4'b0, 2'b0);
        end
    endtask

    // One clk_1Hz rising edge; the request rides in the tick cycle.
    task automatic do_tick(bit [3:0] adds, bit [1:0] pres);
        clk_1Hz = 1'b1;
        drive_cycle(1'b0, adds, pres);
        idle(2);
        clk_1Hz = 1'b0;
        idle(3);
    endtask

    initial begin
        rst = 1'b1; clk_1Hz = 1'b0; clk_blink = 1'b0;
        add_a = 0; add_b = 0; add_c = 0; add_d = 0; pre_a = 0; pre_b = 0;
        drive_cycle(1'b1, 4'b0, 2'b0);

        // Scoreboard monitor: a completed conversion must match the last secs change 16 edges earlier.
        fork
            begin
                logic        pv;
                logic [15:0] pb;
                int          c;
                pv = bcd_valid;
                pb = bcd;
                forever begin
                    @(negedge clk);
                    if (bcd_valid && !pv && model_edge != rst_edge) begin
                        c = model_edge;
                        while (q.size() > 0 && q[0].e < c - 16) void'(q.pop_front());
                        if (q.size() > 0 && q[0].e == c - 16) begin
                            check("bcd_result", int'(bcd), to_bcd(q[0].v));
                            $display("[TB] conversion: bcd %04h for secs %0d at edge %0d", bcd, q[0].v, c);
                            void'(q.pop_front());
                        end else begin
                            check("bcd_timing", c, (q.size() > 0) ? q[0].e + 16 : -1);
                        end
                    end else if (bcd != pb && model_edge != rst_edge) begin
                        check("bcd_partial", int'(bcd), int'(pb));
                    end
                    pv = bcd_valid;
                    pb = bcd;
                end
            end
        join_none

        // 1: reset, then idle
        drive_cycle(1'b1, 4'b0, 2'b0);
        drive_cycle(1'b1, 4'b0, 2'b0);
        idle(4);
        check("t1_bcd", int'(bcd), 16'h0000);

        // 2: pre_b then five ticks
        drive_cycle(1'b0, 4'b0, 2'b10);
        for (int i = 0; i < 5; i++) do_tick(4'b0, 2'b0);
        idle(20);
        check("t2_secs", int'(secs), 180);
        check("t2_bcd", int'(bcd), 16'h0180);

        // 3: add_d, then saturate
        drive_cycle(1'b0, 4'b1000, 2'b0);
        idle(20);
        check("t3_secs", int'(secs), 480);
        for (int i = 0; i < 33; i++) begin
            drive_cycle(1'b0, 4'b1000, 2'b0);
            idle(2);
        end
        idle(20);
        check("t3_bcd_sat", int'(bcd), 16'h9999);

        // 4: add with tick, preset with add and tick
        drive_cycle(1'b0, 4'b0, 2'b01);
        idle(2);
        do_tick(4'b0001, 2'b0);
        check("t4_add_tick", int'(secs), 74);
        do_tick(4'b0100, 2'b01);
        check("t4_pre_add_tick", int'(secs), 15);

        // 5: count down to zero without wrap
        drive_cycle(1'b0, 4'b0, 2'b01);
        for (int i = 0; i < 20; i++) do_tick(4'b0, 2'b0);
        check("t5_zero", int'(secs), 0);
        idle(20);

        // 6: add mid-conversion, then reset mid-conversion
        drive_cycle(1'b0, 4'b0010, 2'b0);
        idle(2);
        drive_cycle(1'b0, 4'b0001, 2'b0);
        idle(20);
        check("t6_bcd", int'(bcd), 16'h0180);
        drive_cycle(1'b0, 4'b0100, 2'b0);
        idle(5);
        drive_cycle(1'b1, 4'b0, 2'b0);
        idle(3);

        // Random phase
        for (int i = 0; i < 2000; i++) begin
            bit [3:0] adds;
            bit [1:0] pres;
            bit       r;
            if ($urandom_range(0, 11) == 0) clk_1Hz = ~clk_1Hz;
            if ($urandom_range(0, 2) == 0)  clk_blink = ~clk_blink;
            adds = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            pres = ($urandom_range(0, 79) == 0) ? 2'($urandom_range(1, 3)) : 2'b0;
            r    = ($urandom_range(0, 499) == 0);
            drive_cycle(r, adds, pres);
        end
        idle(25);
        check("final_bcd", int'(bcd), to_bcd(m_secs));
        check("final_valid", int'(bcd_valid), 1);
        check("final_queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
